// File: rtl/park_pkg.sv
// Shared parking-timer definitions: FSM states, timer range and the build-time wrap-counter switch.
// PARK_WRAP_COUNT_EN enables per-slot wrap counters so stays longer than one timer period bill correctly.
package park_pkg;
  localparam int              TMR_W     = 10;
  localparam logic [TMR_W-1:0] TIMER_MAX = 10'd999;
  localparam int              PERIOD    = 1000;

  typedef enum logic [1:0] {IDLE, DIFF, FEE, DONE} state_e;

`ifdef PARK_WRAP_COUNT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
endpackage

// File: rtl/park_slot_regs.sv
// Per-slot occupancy, entry timestamp and (with PARK_WRAP_COUNT_EN) timer-wrap counter.
// Entry to an occupied slot is rejected; exits clear occupancy via clr_req.
module park_slot_regs
  import park_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
`ifdef PARK_WRAP_COUNT_EN
  , parameter int WRAP_W  = 4
`endif
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [TMR_W-1:0]                 timer_count,
  input  logic                             entry_req,
  input  logic [SLOT_W-1:0]                entry_slot,
  input  logic                             clr_req,
  input  logic [SLOT_W-1:0]                clr_slot,
  output logic [NUM_SLOTS-1:0]             occupied,
  output logic [NUM_SLOTS-1:0][TMR_W-1:0]  stamp,
`ifdef PARK_WRAP_COUNT_EN
  output logic [NUM_SLOTS-1:0][WRAP_W-1:0] wraps,
`endif
  output logic                             entry_rej
);

  assign entry_rej = entry_req && occupied[entry_slot];

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic             occ_q;
    logic [TMR_W-1:0] stamp_q;
    logic             hit;

    assign hit = entry_req && (entry_slot == SLOT_W'(s)) && !occ_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        occ_q   <= 1'b0;
        stamp_q <= '0;
      end else if (hit) begin
        occ_q   <= 1'b1;
        stamp_q <= timer_count;
      end else if (clr_req && (clr_slot == SLOT_W'(s))) begin
        occ_q   <= 1'b0;
      end
    end

`ifdef PARK_WRAP_COUNT_EN
    logic [WRAP_W-1:0] wrap_q;

    // Occupancy only goes high after the entry edge, so the entry cycle never counts.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        wrap_q <= '0;
      else if (hit)
        wrap_q <= '0;
      else if (occ_q && (timer_count == TIMER_MAX) && (wrap_q != '1))
        wrap_q <= wrap_q + 1'b1;
    end

    assign wraps[s] = wrap_q;
`endif

    assign occupied[s] = occ_q;
    assign stamp[s]    = stamp_q;
  end

endmodule

// File: rtl/parking_fee_calc.sv
// Parking fee calculator: stamps entries, and on exit computes elapsed ticks and an iterative fee.
// PARK_WRAP_COUNT_EN widens duration to cover multiple timer periods.
module parking_fee_calc
  import park_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_W         = 2,
  parameter int TICKS_PER_UNIT = 100,
  parameter int RATE           = 5,
  parameter int FEE_W          = 12,
  parameter int WRAP_W         = 4,
  // derived from the build; do not override
  parameter int DUR_W          = TMR_W + (WRAP_EN ? WRAP_W : 0)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TMR_W-1:0]     timer_count,
  input  logic                 entry_req,
  input  logic [SLOT_W-1:0]    entry_slot,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 busy,
  output logic                 done,
  output logic [SLOT_W-1:0]    done_slot,
  output logic [DUR_W-1:0]     duration,
  output logic [FEE_W-1:0]     fee,
  output logic                 err
);

  state_e                            state_q;
  logic [SLOT_W-1:0]                 slot_q, done_slot_q;
  logic [TMR_W-1:0]                  now_q, stamp_lat_q;
  logic [DUR_W-1:0]                  d_q, rem_q, dur_q;
  logic [DUR_W-1:0]                  diff_d, rem_d;
  logic [FEE_W-1:0]                  acc_q, fee_q, acc_d;
  logic                              busy_q, done_q, err_q;
  logic                              exit_ok, entry_rej;
  logic [NUM_SLOTS-1:0][TMR_W-1:0]   stamp;
`ifdef PARK_WRAP_COUNT_EN
  logic [NUM_SLOTS-1:0][WRAP_W-1:0]  wraps;
  logic [WRAP_W-1:0]                 wrap_lat_q;
`endif

  assign exit_ok = exit_req && (state_q == IDLE) && occupied[exit_slot];

  park_slot_regs #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
`ifdef PARK_WRAP_COUNT_EN
    , .WRAP_W  (WRAP_W)
`endif
  ) u_slots (
    .clk         (clk),
    .reset       (reset),
    .timer_count (timer_count),
    .entry_req   (entry_req),
    .entry_slot  (entry_slot),
    .clr_req     (exit_ok),
    .clr_slot    (exit_slot),
    .occupied    (occupied),
    .stamp       (stamp),
`ifdef PARK_WRAP_COUNT_EN
    .wraps       (wraps),
`endif
    .entry_rej   (entry_rej)
  );

  always_comb begin
    diff_d = '0;
    if (now_q >= stamp_lat_q)
      diff_d = DUR_W'(now_q - stamp_lat_q);
    else
      diff_d = DUR_W'({1'b0, now_q} + (TMR_W+1)'(PERIOD) - {1'b0, stamp_lat_q});
`ifdef PARK_WRAP_COUNT_EN
    // Each counted wrap is one full period; a "now<stamp" stay already contains one of them.
    diff_d = diff_d + DUR_W'(wrap_lat_q) * DUR_W'(PERIOD);
    if (now_q < stamp_lat_q)
      diff_d = diff_d - DUR_W'(PERIOD);
`endif
  end

  always_comb begin
    rem_d = (rem_q > DUR_W'(TICKS_PER_UNIT)) ? rem_q - DUR_W'(TICKS_PER_UNIT) : '0;
    acc_d = (acc_q > {FEE_W{1'b1}} - FEE_W'(RATE)) ? {FEE_W{1'b1}} : acc_q + FEE_W'(RATE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      done_slot_q <= '0;
      now_q       <= '0;
      stamp_lat_q <= '0;
      d_q         <= '0;
      rem_q       <= '0;
      dur_q       <= '0;
      acc_q       <= '0;
      fee_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PARK_WRAP_COUNT_EN
      wrap_lat_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= entry_rej || (exit_req && !exit_ok);
      case (state_q)
        IDLE: if (exit_ok) begin
          // Latch the slot's record now: the wrap counter may still tick on this edge.
          slot_q      <= exit_slot;
          now_q       <= timer_count;
          stamp_lat_q <= stamp[exit_slot];
`ifdef PARK_WRAP_COUNT_EN
          wrap_lat_q  <= wraps[exit_slot];
`endif
          busy_q      <= 1'b1;
          state_q     <= DIFF;
        end
        DIFF: begin
          d_q     <= diff_d;
          rem_q   <= diff_d;
          acc_q   <= '0;
          state_q <= FEE;
        end
        FEE: begin
          if (rem_q == '0) begin
            state_q <= DONE;
          end else begin
            rem_q <= rem_d;
            acc_q <= acc_d;
          end
        end
        DONE: begin
          done_q      <= 1'b1;
          dur_q       <= d_q;
          fee_q       <= acc_q;
          done_slot_q <= slot_q;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign done_slot = done_slot_q;
  assign duration  = dur_q;
  assign fee       = fee_q;
  assign err       = err_q;

endmodule

// File: tb/tb_parking_fee_calc.sv
// Self-checking bench for parking_fee_calc: directed scenarios plus randomized stays checked
// against an absolute-cycle-count model of occupancy, elapsed time and billing.
module tb_parking_fee_calc;
`ifdef PARK_WRAP_COUNT_EN
  localparam int DW = 14;
`else
  localparam int DW = 10;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [9:0]    tc = '0;
  logic          entry_req = 1'b0, exit_req = 1'b0;
  logic [1:0]    entry_slot = '0, exit_slot = '0;
  logic [3:0]    occupied;
  logic          busy, done, err;
  logic [1:0]    done_slot;
  logic [DW-1:0] duration;
  logic [11:0]   fee;

  int n_vec = 0, n_bad = 0, cnt = 0;
  bit occ_m[4];
  int ent_idx[4];

  always #5 clk = ~clk;

  parking_fee_calc dut (
    .clk(clk), .reset(reset), .timer_count(tc),
    .entry_req(entry_req), .entry_slot(entry_slot),
    .exit_req(exit_req), .exit_slot(exit_slot),
    .occupied(occupied), .busy(busy), .done(done), .done_slot(done_slot),
    .duration(duration), .fee(fee), .err(err)
  );

  // One clock edge; the free-running timer advances and request pulses drop.
  task automatic cyc();
    @(posedge clk); #1;
    cnt++;
    tc = (tc == 10'd999) ? 10'd0 : tc + 10'd1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  task automatic goto_tc(input int v);
    while (int'(tc) != v) cyc();
  endtask

  function automatic logic [3:0] occ_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = occ_m[i];
    return v;
  endfunction

  function automatic int exp_dur(input int el);
`ifdef PARK_WRAP_COUNT_EN
    return el;
`else
    return el % 1000;
`endif
  endfunction

  function automatic int exp_fee(input int d);
    int f;
    f = ((d + 99) / 100) * 5;
    return (f > 4095) ? 4095 : f;
  endfunction

  task automatic do_entry(input int s, input bit exp_rej);
    entry_req = 1'b1; entry_slot = 2'(s);
    cyc();
    if (!exp_rej) begin occ_m[s] = 1'b1; ent_idx[s] = cnt; end
    n_vec++;
    if (err !== exp_rej) begin n_bad++; $display("FAIL entry_err slot%0d: got %b want %b", s, err, exp_rej); end
    n_vec++;
    if (occupied !== occ_vec()) begin n_bad++; $display("FAIL entry_occ slot%0d: got %b want %b", s, occupied, occ_vec()); end
  endtask

  task automatic wait_bill(input int s, input int el, input int lat0);
    int d, lat, exp_lat;
    bit seen;
    d = exp_dur(el); lat = lat0; seen = 1'b0;
    exp_lat = 3 + (d + 99) / 100;
    while (!seen && lat < lat0 + 300) begin
      cyc(); lat++;
      if (done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_bad++; $display("FAIL done_timeout slot%0d: no done within %0d cycles", s, lat); end
    n_vec++;
    if (lat != exp_lat) begin n_bad++; $display("FAIL latency slot%0d: got %0d want %0d", s, lat, exp_lat); end
    n_vec++;
    if (duration !== DW'(d)) begin n_bad++; $display("FAIL duration slot%0d: got %0d want %0d", s, duration, d); end
    n_vec++;
    if (fee !== 12'(exp_fee(d))) begin n_bad++; $display("FAIL fee slot%0d: got %0d want %0d", s, fee, exp_fee(d)); end
    n_vec++;
    if (done_slot !== 2'(s)) begin n_bad++; $display("FAIL done_slot: got %0d want %0d", done_slot, s); end
    cyc();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL post_done slot%0d: done=%b busy=%b want 0 0", s, done, busy); end
  endtask

  task automatic start_exit(input int s, output int el);
    exit_req = 1'b1; exit_slot = 2'(s);
    cyc();
    el = cnt - ent_idx[s];
    occ_m[s] = 1'b0;
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL exit_start slot%0d: err=%b busy=%b want 0 1", s, err, busy); end
    n_vec++;
    if (occupied !== occ_vec()) begin n_bad++; $display("FAIL exit_occ slot%0d: got %b want %b", s, occupied, occ_vec()); end
  endtask

  task automatic do_exit(input int s);
    int el;
    start_exit(s, el);
    wait_bill(s, el, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    n_vec++;
    if ({occupied, busy, done, done_slot, err} !== '0 || duration !== '0 || fee !== '0) begin
      n_bad++; $display("FAIL reset_state: occ=%b busy=%b done=%b slot=%0d dur=%0d fee=%0d err=%b want all 0",
                        occupied, busy, done, done_slot, duration, fee, err);
    end
    reset = 1'b0;
    cyc();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || occupied !== 4'b0) begin n_bad++; $display("FAIL post_reset: busy=%b done=%b occ=%b want 0 0 0", busy, done, occupied); end
  endtask

  task automatic test_basic();
    goto_tc(100); do_entry(0, 1'b0);
    goto_tc(350); do_exit(0);
  endtask

  task automatic test_wrap();
    goto_tc(900); do_entry(1, 1'b0);
    goto_tc(50);  do_exit(1);
  endtask

  task automatic test_errors();
    int el;
    goto_tc(10);
    do_entry(2, 1'b0);
    do_entry(1, 1'b0);
    do_entry(2, 1'b1);
    exit_req = 1'b1; exit_slot = 2'd3;
    cyc();
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0 || occupied !== occ_vec()) begin
      n_bad++; $display("FAIL exit_empty: err=%b busy=%b occ=%b want 1 0 %b", err, busy, occupied, occ_vec());
    end
    // two rejections in one cycle -> a single one-cycle err pulse
    entry_req = 1'b1; entry_slot = 2'd2; exit_req = 1'b1; exit_slot = 2'd3;
    cyc();
    n_vec++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL dual_reject: got err=%b want 1", err); end
    cyc();
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width: got err=%b want 0", err); end
    start_exit(2, el);
    exit_req = 1'b1; exit_slot = 2'd1;
    cyc();
    n_vec++;
    if (err !== 1'b1 || occupied !== occ_vec()) begin
      n_bad++; $display("FAIL exit_busy: err=%b occ=%b want 1 %b", err, occupied, occ_vec());
    end
    wait_bill(2, el, 1);
    do_exit(1);
  endtask

  task automatic test_same_cycle();
    int el;
    do_entry(0, 1'b0);
    repeat (40) cyc();
    entry_req = 1'b1; entry_slot = 2'd0; exit_req = 1'b1; exit_slot = 2'd0;
    cyc();
    el = cnt - ent_idx[0];
    occ_m[0] = 1'b0;
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b1 || occupied !== occ_vec()) begin
      n_bad++; $display("FAIL same_cycle: err=%b busy=%b occ=%b want 1 1 %b", err, busy, occupied, occ_vec());
    end
    wait_bill(0, el, 0);
  endtask

  task automatic test_long_stay();
    goto_tc(200); do_entry(2, 1'b0);
    repeat (2099) cyc();
    do_exit(2);
  endtask

  task automatic test_reset_mid();
    int el;
    bit saw_done;
    do_entry(3, 1'b0);
    repeat (499) cyc();
    start_exit(3, el);
    cyc(); cyc();
    reset = 1'b1; #1;
    for (int i = 0; i < 4; i++) occ_m[i] = 1'b0;
    n_vec++;
    if ({occupied, busy, done, done_slot, err} !== '0 || duration !== '0 || fee !== '0) begin
      n_bad++; $display("FAIL reset_mid: occ=%b busy=%b done=%b slot=%0d dur=%0d fee=%0d err=%b want all 0",
                        occupied, busy, done, done_slot, duration, fee, err);
    end
    cyc();
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin cyc(); if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
    n_vec++;
    if (saw_done) begin n_bad++; $display("FAIL reset_abort: done/busy seen after abort, want none"); end
    do_entry(3, 1'b0);
    repeat (119) cyc();
    do_exit(3);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int s, r;
      s = $urandom_range(0, 3);
      r = $urandom_range(0, 1200);
      if (!occ_m[s]) do_entry(s, 1'b0);
      for (int k = 0; k < r; k++) begin
        if ($urandom_range(0, 63) == 0) begin
          int o;
          o = $urandom_range(0, 3);
          if (o != s) do_entry(o, occ_m[o]); else cyc();
        end else begin
          cyc();
        end
      end
      do_exit(s);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_errors();
    test_same_cycle();
    test_long_stay();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
